chunk_serial_adder: RTL and testbench
=====================================

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 3, meaning bits added per cycle; CHUNK in 1..WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  sum, cout, ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  raw carry-out of the MSB chunk.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Elaboration SHALL fail if WIDTH mod CHUNK != 0; N = WIDTH/CHUNK chunks.
REQ-018 Arithmetic: sub=0 -> a + b + cin; sub=1 -> a + ~b + (1 - cin), i.e. a - b - cin; initial carry = cin XOR sub.
REQ-019 Chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) SHALL be added at RUN cycle k, LSB chunk first, carry held in a 1-bit register between chunks.
REQ-020 cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 FSM states IDLE, RUN, DONE; IDLE -> RUN on in_valid & in_ready; RUN -> DONE after chunk N-1; DONE -> IDLE on out_valid & out_ready.
REQ-022 in_ready SHALL be 1 exactly in IDLE with rst low; operands, cin, sub are captured into internal registers at acceptance and input changes afterwards are ignored.
REQ-023 Latency: operand accepted at edge T -> out_valid first high in cycle after edge T+N+1 (N RUN cycles plus one to DONE).
REQ-024 out_valid SHALL be 1 exactly in DONE; sum, cout, ovf SHALL hold stable while out_valid is high and out_ready low (arbitrarily long backpressure).
REQ-025 No new operand accepted in DONE; earliest next acceptance is the cycle after the output handshake.
REQ-026 sum bits not yet computed during RUN SHALL not be visible as valid (out_valid low); chunk counter wraps to 0 on entering IDLE.
REQ-027 N=1 (CHUNK=WIDTH) SHALL work: one RUN cycle, latency 2.

Reset
REQ-028 While rst is high at a clock edge: state -> IDLE, out_valid 0, sum 0, cout 0, ovf 0, carry and chunk counter 0; in_ready 0 while rst is high, 1 the first cycle after rst low.
REQ-029 Reset in RUN or DONE SHALL abort the operation with no result emitted; reset has priority over simultaneous handshakes.

Verification (WIDTH=12, CHUNK=3, N=4 unless stated)
REQ-030 Add a=0xFFF, b=0x001, cin=0, sub=0 -> sum=0x000, cout=1, ovf=0, out_valid 5 cycles after acceptance.
REQ-031 Add a=0x7FF, b=0x001, cin=0 -> sum=0x800, cout=0, ovf=1; add a=0x003, b=0x004, cin=1 -> sum=0x008.
REQ-032 Subtract a=0x005, b=0x007, cin=0, sub=1 -> sum=0xFFE, cout=0, ovf=0; a=0x800, b=0x001 -> sum=0x7FF, cout=1, ovf=1.
REQ-033 Backpressure: out_ready low 3 cycles in DONE with in_valid held high -> outputs stable, in_ready 0; second operand accepted the cycle after the out handshake.
REQ-034 rst pulsed 1 cycle during RUN chunk 2 -> next cycle IDLE, out_valid 0, sum 0; in_ready 1 after rst low; no stale result appears.
REQ-035 CHUNK=12 (N=1): a=0x800, b=0x800 add -> sum=0x000, cout=1, ovf=1, out_valid 2 cycles after acceptance; WIDTH=12, CHUNK=5 -> elaboration error.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Bit-serial-by-chunk adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module chunk_serial_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the producer holds its data while valid is high.

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("chunk_serial_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] NCNT = CW'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_msb_in;

  // The counter sits at N for the single settle cycle before DONE; keep the slice index in range.
  always_comb begin
    idx      = (cnt == NCNT) ? '0 : cnt;
    a_c      = a_q[idx*CHUNK +: CHUNK];
    b_c      = b_q[idx*CHUNK +: CHUNK];
    {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    c_msb_in = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is folded into the capture: invert b, initial carry = cin ^ sub.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == NCNT) begin
            state <= S_DONE;
          end else begin
            sum_q[idx*CHUNK +: CHUNK] <= s_c;
            carry <= c_out;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              cout_q <= c_out;
              ovf_q  <= c_msb_in ^ c_out;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: WIDTH=12/CHUNK=3 main instance with a cycle-level model
// check, plus a WIDTH=12/CHUNK=12 instance exercised with directed vectors.
module tb_chunk_serial_adder;

  localparam int W  = 12;
  localparam int C0 = 3;
  localparam int N0 = W / C0;
  localparam int C1 = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic [1:0]   state_dbg;

  logic         n1_in_valid, n1_in_ready, n1_cin, n1_sub, n1_out_valid, n1_out_ready;
  logic         n1_cout, n1_ovf;
  logic [W-1:0] n1_a, n1_b, n1_sum;
  logic [1:0]   n1_state_dbg;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(C0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .state_dbg(state_dbg)
  );

  chunk_serial_adder #(.WIDTH(W), .CHUNK(C1)) u_dut_n1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .a(n1_a), .b(n1_b),
    .cin(n1_cin), .sub(n1_sub), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .sum(n1_sum), .cout(n1_cout), .ovf(n1_ovf), .state_dbg(n1_state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    int           acc;
  } op_t;

  op_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_acc = 0;
  int  last_hs  = 0;

  // Returns {ovf, cout, sum} from plain two's-complement arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(ci ^ s);
    v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back('{a: a, b: b, cin: cin, sub: sub, acc: cyc + 1});
      last_acc <= cyc + 1;
    end
    if (!rst && out_valid && out_ready) last_hs <= cyc + 1;
  end

  task automatic compare_cycle();
    logic          exp_v;
    logic [W+1:0]  r;
    exp_v = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= N0 + 1);
    check("out_valid", out_valid, exp_v);
    check("in_ready", in_ready, exp_q.size() == 0);
    if (out_valid && exp_q.size() > 0) begin
      r = model(exp_q[0].a, exp_q[0].b, exp_q[0].cin, exp_q[0].sub);
      check("model_sum", sum, r[W-1:0]);
      check("model_cout", cout, r[W]);
      check("model_ovf", ovf, r[W+1]);
      if (out_ready) void'(exp_q.pop_front());
    end
  endtask

  always @(negedge clk) if (!rst) compare_cycle();

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    bit done = 1'b0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    check("accept_timeout", done, 1);
    in_valid = 1'b0;
    a = W'($urandom_range(0, (1 << W) - 1));
    b = W'($urandom_range(0, (1 << W) - 1));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec,
                             input logic eo, input int lat);
    int k = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      k++;
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check({nm, "_timeout"}, seen, 1);
    if (seen) begin
      check({nm, "_latency"}, k, lat);
      check({nm, "_sum"}, sum, es);
      check({nm, "_cout"}, cout, ec);
      check({nm, "_ovf"}, ovf, eo);
      if (out_ready) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    drive(x, y, ci, s);
    wait_result(nm, es, ec, eo, 5);
  endtask

  task automatic n1_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    bit done = 1'b0;
    bit seen = 1'b0;
    int k = 0;
    logic [W+1:0] r;
    n1_a = x; n1_b = y; n1_cin = ci; n1_sub = s; n1_in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (n1_in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    check({nm, "_accept"}, done, 1);
    n1_in_valid = 1'b0;
    n1_a = ~x; n1_b = ~y;
    for (int i = 0; i < 20 && !seen; i++) begin
      k++;
      @(posedge clk); #1;
      if (n1_out_valid) seen = 1'b1;
    end
    check({nm, "_timeout"}, seen, 1);
    if (seen) begin
      r = model(x, y, ci, s);
      check({nm, "_latency"}, k, 2);
      check({nm, "_sum"}, n1_sum, es);
      check({nm, "_cout"}, n1_cout, ec);
      check({nm, "_ovf"}, n1_ovf, eo);
      check({nm, "_model"}, {n1_ovf, n1_cout, n1_sum}, r);
      @(posedge clk); #1;
      check({nm, "_out_valid_after"}, n1_out_valid, 0);
      check({nm, "_in_ready_after"}, n1_in_ready, 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    n1_in_valid = 1'b0; n1_out_ready = 1'b1; n1_a = '0; n1_b = '0; n1_cin = 1'b0; n1_sub = 1'b0;

    // Pin the model itself against hand-computed results.
    check("pin_model_wrap", model(12'hFFF, 12'h001, 1'b0, 1'b0), {1'b0, 1'b1, 12'h000});
    check("pin_model_sub_ovf", model(12'h800, 12'h001, 1'b0, 1'b1), {1'b1, 1'b1, 12'h7FF});

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_op("add_wrap",   12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    run_op("add_ovf",    12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
    run_op("add_cin",    12'h003, 12'h004, 1'b1, 1'b0, 12'h008, 1'b0, 1'b0);
    run_op("sub_neg",    12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
    run_op("sub_mixed",  12'hABC, 12'h123, 1'b0, 1'b1, 12'h999, 1'b1, 1'b0);
    run_op("sub_borrow", 12'h010, 12'h005, 1'b1, 1'b1, 12'h00A, 1'b1, 1'b0);

    // Backpressure with the next operand already waiting.
    out_ready = 1'b0;
    drive(12'h555, 12'h0AA, 1'b0, 1'b0);
    a = 12'h001; b = 12'h002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    wait_result("bp", 12'h5FF, 1'b0, 1'b0, 5);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_sum", sum, 12'h5FF);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_accept_gap", last_acc - last_hs, 1);
    in_valid = 1'b0;
    wait_result("bp_next", 12'h003, 1'b0, 1'b0, 5);

    // Reset pulse during RUN chunk 2 aborts the operation.
    drive(12'h7FF, 12'h7FF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    run_op("after_abort", 12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 1'b0);

    // Single-chunk instance.
    n1_op("n1_add", 12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    n1_op("n1_sub", 12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
